// File: rtl/param_seq_detector.sv
// Streaming sequence detector: compares the last DEPTH accepted symbols against
// PATTERN and reports hits as a registered one-cycle pulse plus a saturating counter.
module param_seq_detector #(
    parameter int SYM_W   = 2,
    parameter int DEPTH   = 4,
    parameter     PATTERN = {2'b01, 2'b01, 2'b10, 2'b00},
    parameter bit OVERLAP = 1'b1,
    parameter int CNT_W   = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [SYM_W-1:0]           in,
    input  logic                       clear,
    output logic                       match,
    output logic [CNT_W-1:0]           count,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic                       overflow
);

    localparam int HIST_W = SYM_W * DEPTH;
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam logic [HIST_W-1:0] PAT      = PATTERN;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

    if ($bits(PATTERN) != HIST_W) begin : g_bad_pattern
        $error("PATTERN width %0d does not equal SYM_W*DEPTH = %0d", $bits(PATTERN), HIST_W);
    end
    if (SYM_W < 1 || DEPTH < 2) begin : g_bad_geometry
        $error("SYM_W must be >= 1 and DEPTH must be >= 2");
    end

    logic [HIST_W-1:0] hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              match_q, match_d;
    logic              ovf_q, ovf_d;
    logic [HIST_W-1:0] hist_shift;
    logic              hit;

    // Newest symbol enters the LSB slice; fill gates the compare so stale history never hits.
    always_comb begin
        hist_shift = {hist_q[HIST_W-SYM_W-1:0], in};
        fill_inc   = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
        hit        = (fill_inc == FILL_MAX) && (hist_shift == PAT);

        hist_d  = hist_q;
        fill_d  = fill_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        match_d = 1'b0;

        if (clear) begin
            hist_d  = '0;
            fill_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (in_valid) begin
            hist_d  = hist_shift;
            match_d = hit;
            fill_d  = (hit && !OVERLAP) ? '0 : fill_inc;
            if (hit) begin
                if (&count_q) begin
                    ovf_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q  <= '0;
            fill_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            match_q <= match_d;
        end
    end

    assign match    = match_q;
    assign count    = count_q;
    assign fill     = fill_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_param_seq_detector.sv
// Bench for param_seq_detector: three instances (default pattern, all-01 overlapping,
// all-01 non-overlapping) share one stimulus stream and are checked against a queue-fed model.
module tb_param_seq_detector;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [1:0] sym;
    logic       clear;

    logic       match_w [3];
    logic [2:0] count_w [3];
    logic [2:0] fill_w  [3];
    logic       ovf_w   [3];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] hist;
        int         fill;
        int         cnt;
        logic       ovf;
        logic       m;
    } mdl_t;

    mdl_t       mdl [3];
    logic [7:0] pat [3] = '{8'b01011000, 8'b01010101, 8'b01010101};
    bit         ovl [3] = '{1'b1, 1'b1, 1'b0};

    logic [W-1:0] exp_q [3][$];

    always #5 clk = ~clk;

    param_seq_detector u_def (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(sym), .clear(clear),
        .match(match_w[0]), .count(count_w[0]), .fill(fill_w[0]), .overflow(ovf_w[0])
    );

    param_seq_detector #(.PATTERN(8'b01010101), .OVERLAP(1'b1)) u_ov (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(sym), .clear(clear),
        .match(match_w[1]), .count(count_w[1]), .fill(fill_w[1]), .overflow(ovf_w[1])
    );

    param_seq_detector #(.PATTERN(8'b01010101), .OVERLAP(1'b0)) u_no (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in(sym), .clear(clear),
        .match(match_w[2]), .count(count_w[2]), .fill(fill_w[2]), .overflow(ovf_w[2])
    );

    function automatic logic [W-1:0] pack_exp(mdl_t s);
        return {s.m, 3'(s.cnt), 3'(s.fill), s.ovf};
    endfunction

    function automatic logic [W-1:0] pack_dut(int i);
        return {match_w[i], count_w[i], fill_w[i], ovf_w[i]};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mdl[i].hist = '0;
            mdl[i].fill = 0;
            mdl[i].cnt  = 0;
            mdl[i].ovf  = 1'b0;
            mdl[i].m    = 1'b0;
        end
    endtask

    // Apply one edge of stimulus: push expected state, clock, pop and compare.
    task automatic step(input string tag, input logic v, input logic [1:0] s, input logic c);
        logic [7:0] hn;
        int         fn;
        bit         hit;
        in_valid = v;
        sym      = s;
        clear    = c;
        for (int i = 0; i < 3; i++) begin
            if (c) begin
                mdl[i].hist = '0;
                mdl[i].fill = 0;
                mdl[i].cnt  = 0;
                mdl[i].ovf  = 1'b0;
                mdl[i].m    = 1'b0;
            end else if (v) begin
                hn  = {mdl[i].hist[5:0], s};
                fn  = (mdl[i].fill == 4) ? 4 : mdl[i].fill + 1;
                hit = (fn == 4) && (hn == pat[i]);
                mdl[i].hist = hn;
                mdl[i].m    = hit;
                mdl[i].fill = (hit && !ovl[i]) ? 0 : fn;
                if (hit) begin
                    if (mdl[i].cnt == 7) mdl[i].ovf = 1'b1;
                    else mdl[i].cnt++;
                end
            end else begin
                mdl[i].m = 1'b0;
            end
            exp_q[i].push_back(pack_exp(mdl[i]));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s/dut%0d", tag, i), pack_dut(i), exp_q[i].pop_front());
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s/dut%0d", tag, i), pack_dut(i), '0);
        end
    endtask

    initial begin
        logic [1:0] seq_def [4];
        logic [1:0] seq_miss [4];
        seq_def  = '{2'b01, 2'b01, 2'b10, 2'b00};
        seq_miss = '{2'b01, 2'b00, 2'b00, 2'b11};

        reset    = 1'b0;
        in_valid = 1'b0;
        sym      = 2'b00;
        clear    = 1'b0;
        model_reset();
        #1;
        check_all_zero("reset_init");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Default pattern: fill climbs 1..4, pulse only after the closing 00.
        for (int k = 0; k < 4; k++) begin
            step("def_pat", 1'b1, seq_def[k], 1'b0);
            check("def_fill", W'(fill_w[0]), W'(k + 1));
        end
        check("def_match", W'(match_w[0]), W'(1));
        check("def_count", W'(count_w[0]), W'(1));
        for (int k = 0; k < 4; k++) begin
            step("def_miss", 1'b1, seq_miss[k], 1'b0);
            check("miss_nomatch", W'(match_w[0]), W'(0));
        end
        check("miss_count", W'(count_w[0]), W'(1));

        // Reset mid-stream while in_valid is held high.
        in_valid = 1'b1;
        sym      = 2'b01;
        reset    = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) exp_q[i].delete();
        #1;
        check_all_zero("reset_async");
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all_zero("reset_hold");
        end
        @(negedge clk);
        reset = 1'b1;

        // Idle gaps between pattern symbols do not break the match.
        step("gap", 1'b1, 2'b01, 1'b0);
        step("gap", 1'b1, 2'b01, 1'b0);
        step("gap_idle", 1'b0, 2'b10, 1'b0);
        check("gap_fill_hold", W'(fill_w[0]), W'(2));
        step("gap_idle", 1'b0, 2'b00, 1'b0);
        check("gap_fill_hold", W'(fill_w[0]), W'(2));
        step("gap", 1'b1, 2'b10, 1'b0);
        step("gap", 1'b1, 2'b00, 1'b0);
        check("gap_match", W'(match_w[0]), W'(1));
        check("gap_count", W'(count_w[0]), W'(1));
        step("gap_after", 1'b0, 2'b00, 1'b0);
        check("pulse_one_cycle", W'(match_w[0]), W'(0));

        // All-01 stream: overlapping vs non-overlapping detection.
        step("clr", 1'b0, 2'b00, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            step($sformatf("ovl_sym%0d", k), 1'b1, 2'b01, 1'b0);
            if (k == 4) check("no_fill_flush", W'(fill_w[2]), W'(0));
            if (k == 6) check("ov_count6", W'(count_w[1]), W'(3));
        end
        check("no_count8", W'(count_w[2]), W'(2));
        check("no_match8", W'(match_w[2]), W'(1));

        // Saturation: eight default-pattern hits with random idle gaps.
        step("clr", 1'b0, 2'b00, 1'b1);
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 3) == 0) step("sat_idle", 1'b0, 2'($urandom_range(0, 3)), 1'b0);
                step($sformatf("sat_m%0d", n), 1'b1, seq_def[k], 1'b0);
            end
            if (n == 6) check("sat_ovf_low", W'(ovf_w[0]), W'(0));
        end
        check("sat_count", W'(count_w[0]), W'(7));
        check("sat_ovf", W'(ovf_w[0]), W'(1));
        step("sat_hold", 1'b0, 2'b00, 1'b0);
        check("ovf_sticky", W'(ovf_w[0]), W'(1));

        // Clear wins over a completing symbol on the same edge.
        for (int k = 0; k < 3; k++) step("pre_clr", 1'b1, seq_def[k], 1'b0);
        step("clr_on_hit", 1'b1, 2'b00, 1'b1);
        check("clr_all", pack_dut(0), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_seq_detector.md
Name: param_seq_detector

Overview:
Parameterised streaming sequence detector. It is the successor to the fixed 2-bit-in / 3-bit-out top-level FSM. It accepts one SYM_W-bit symbol per enabled clock and compares the last DEPTH accepted symbols against a compile-time PATTERN. On a hit it raises a registered one-cycle match pulse and bumps a saturating match counter. Overlapping or non-overlapping detection is selected by parameter. It sits directly behind the switch/input sampling logic and drives LED/HEX status outputs.

Parameters:
SYM_W, 2, bits per input symbol (>=1)
DEPTH, 4, pattern length in symbols (>=2)
PATTERN, {2'b01,2'b01,2'b10,2'b00}, SYM_W*DEPTH bits; MSB slice = first (oldest) symbol
OVERLAP, 1, 1 = overlapping matches allowed; 0 = history flushed after each match
CNT_W, 3, match counter width

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  in  1  symbol on in is accepted this edge when 1
in  in  SYM_W  input symbol
clear  in  1  synchronous clear of history, fill, count, overflow, match
match  out  1  one-cycle pulse, high in the cycle after the completing symbol is accepted
count  out  CNT_W  number of matches, saturating
fill  out  $clog2(DEPTH+1)  valid symbols in history, 0..DEPTH
overflow  out  1  sticky; set when a match occurs while count is at maximum

Behaviour:
- Reset (reset==0, async): history=0, fill=0, count=0, match=0, overflow=0. All outputs are registered and read 0 immediately. Release is synchronous to clk. Reset dominates every other input.
- Priority at each rising edge: clear > in_valid > hold.
- clear==1: fill=0, count=0, overflow=0, match=0. Any in_valid symbol on that edge is discarded.
- in_valid==1, clear==0:
  - hist_next = {hist[SYM_W*(DEPTH-1)-1:0], in}. The newest symbol occupies the LSB slice.
  - fill_next = min(fill+1, DEPTH).
  - hit = (fill_next==DEPTH) && (hist_next==PATTERN).
  - match <= hit.
  - On hit, count increments and saturates at 2^CNT_W-1. If count is already at max, count holds and overflow <= 1.
  - On hit with OVERLAP==0: fill <= 0. Later matches need DEPTH fresh symbols. The history register still shifts; its contents are don't-care because fill gates the compare.
  - On hit with OVERLAP==1: fill stays at DEPTH, so the next symbol can complete another match.
- in_valid==0, clear==0: history, fill, count and overflow hold; match <= 0. The pulse never stretches beyond one cycle.
- Latency: match is high for exactly the one clk cycle after the edge that accepted the completing symbol.
- Idle gaps (in_valid low) between pattern symbols do not break a match. Only accepted symbols count.
- No combinational path from any input to any output.
- Elaboration guard: PATTERN width must equal SYM_W*DEPTH, otherwise $error.

Test Plan:
- Reset, defaults: hold reset=0 for 2 cycles mid-stream, then release -> match=0, count=0, fill=0, overflow=0. An asserted in_valid during reset has no effect.
- Default pattern: in_valid=1 with in = 01,01,10,00, one per cycle -> fill counts 1,2,3,4. match is high only in the cycle after 00 is accepted; count=1. Feeding 01,00,00,11 next gives no match; count stays 1.
- Gap tolerance: 01,01, two idle cycles (in_valid=0), then 10,00 -> one match, count=1. fill holds at 2 during the gap.
- Overlap, PATTERN=01 01 01 01, OVERLAP=1: six consecutive 01 -> match pulses after symbols 4, 5 and 6; count=3.
- Same stream with OVERLAP=0: match only after symbol 4, fill returns to 0. Symbols 5..8 of all-01 give a second match at symbol 8; count=2.
- Saturation and clear, CNT_W=3: produce 8 matches -> count=7 and overflow=1 after the 8th. Assert clear together with in_valid on a completing symbol -> match=0, count=0, fill=0, overflow=0 on the next cycle.
